// File: rtl/rancgrid_frame_sequencer_if.sv
// Upstream spike-packet stream into the frame sequencer.
// valid/ready: a packet moves on any cycle with src_valid && src_ready; the source keeps
// src_packet stable and src_valid high until that cycle, and ready never waits on valid.
interface rancgrid_frame_sequencer_if #(
  parameter int PACKET_WIDTH = 30
);
  logic                    src_valid;
  logic [PACKET_WIDTH-1:0] src_packet;
  logic                    src_ready;

  modport master (output src_valid, output src_packet, input src_ready);
  modport slave  (input src_valid, input src_packet, output src_ready);
endinterface

// File: rtl/rancgrid_frame_sequencer.sv
// One RANC inference frame per start: feed packets, drain, tick/tick2/tick3, clear, argmax vote.
// Optional vote snapshot readback port pair: define RANCSEQ_VOTE_READBACK_EN.
module rancgrid_frame_sequencer #(
  parameter int PACKET_WIDTH = 30,
  parameter int OUT_WIDTH    = 8,
  parameter int NUM_CLASSES  = 9,
  parameter int VOTE_WIDTH   = 16,
  parameter int TICK_GAP     = 1024,
  parameter int MAX_PACKETS  = 32768,
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  rancgrid_frame_sequencer_if.slave src,
  output logic [PACKET_WIDTH-1:0] grid_packet_in,
  output logic                    grid_input_buffer_empty,
  input  logic                    grid_ren,
  output logic                    tick,
  output logic                    tick2,
  output logic                    tick3,
  output logic [2:0]              clr_spiked,
  output logic [2:0]              clr_avr,
  input  logic [OUT_WIDTH-1:0]    packet_out,
  input  logic                    packet_out_valid,
  output logic                    busy,
  output logic [CLS_W-1:0]        result_class,
  output logic                    result_valid,
  output logic [15:0]             frame_count,
  output logic                    error,
`ifdef RANCSEQ_VOTE_READBACK_EN
  input  logic [CLS_W-1:0]        vote_rd_idx,
  output logic [VOTE_WIDTH-1:0]   vote_rd_data,
`endif
  output logic [3:0]              state_dbg
);

  localparam int GAP_W = $clog2(TICK_GAP + 1);
  localparam int PKT_W = $clog2(MAX_PACKETS + 1);

  // FEED..CLR are contiguous so the vote window is a simple range check.
  typedef enum logic [3:0] {
    S_IDLE, S_FEED, S_DRAIN, S_G1, S_T1, S_G2, S_T2, S_G3, S_T3, S_G4, S_CLR, S_DECIDE, S_DONE
  } state_t;

  state_t                  state;
  logic                    hold_valid;
  logic [PACKET_WIDTH-1:0] hold_data;
  logic [GAP_W-1:0]        gap_cnt;
  logic [PKT_W-1:0]        pkt_cnt;
  logic [VOTE_WIDTH-1:0]   votes [NUM_CLASSES];
  logic [CLS_W-1:0]        scan_idx;
  logic [CLS_W-1:0]        best_idx;
  logic [VOTE_WIDTH-1:0]   best_val;

  logic                  src_ready_c, xfer, xfer_data, xfer_eof;
  logic                  vote_en, in_gap, gap_done, pkt_limit, last_scan, take;
  logic [CLS_W-1:0]      vote_cls, win_idx;
  logic [VOTE_WIDTH-1:0] scan_val;

  assign src_ready_c = (state == S_FEED) && (!hold_valid || grid_ren);
  assign src.src_ready = src_ready_c;
  assign xfer      = src.src_valid && src_ready_c;
  assign xfer_data = xfer && !src.src_packet[0];
  assign xfer_eof  = xfer && src.src_packet[0];

  assign grid_packet_in          = hold_data;
  assign grid_input_buffer_empty = !hold_valid;
  assign busy                    = (state != S_IDLE);
  assign state_dbg               = state;

  assign vote_en   = (state >= S_FEED) && (state <= S_CLR);
  assign vote_cls  = CLS_W'(packet_out % NUM_CLASSES);
  assign in_gap    = state inside {S_G1, S_G2, S_G3, S_G4};
  assign gap_done  = (gap_cnt == GAP_W'(TICK_GAP - 1));
  assign pkt_limit = (pkt_cnt == PKT_W'(MAX_PACKETS - 1));
  assign last_scan = (scan_idx == CLS_W'(NUM_CLASSES - 1));

  // Strict greater-than keeps the earliest index on ties.
  assign scan_val = votes[scan_idx];
  assign take     = (scan_idx == '0) || (scan_val > best_val);
  assign win_idx  = take ? scan_idx : best_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      gap_cnt      <= '0;
      pkt_cnt      <= '0;
      scan_idx     <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      tick         <= 1'b0;
      tick2        <= 1'b0;
      tick3        <= 1'b0;
      clr_spiked   <= '0;
      clr_avr      <= '0;
      result_class <= '0;
      result_valid <= 1'b0;
      frame_count  <= '0;
      error        <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) votes[i] <= '0;
    end else begin
      tick         <= 1'b0;
      tick2        <= 1'b0;
      tick3        <= 1'b0;
      clr_spiked   <= '0;
      clr_avr      <= '0;
      result_valid <= 1'b0;

      // A load in the same cycle as a grid read replaces the old entry with no bubble.
      if (xfer_data) begin
        hold_valid <= 1'b1;
        hold_data  <= src.src_packet;
      end else if (grid_ren && hold_valid) begin
        hold_valid <= 1'b0;
      end

      if (state == S_DONE) begin
        for (int i = 0; i < NUM_CLASSES; i++) votes[i] <= '0;
      end else if (vote_en && packet_out_valid && (votes[vote_cls] != '1)) begin
        votes[vote_cls] <= votes[vote_cls] + VOTE_WIDTH'(1);
      end

      gap_cnt <= (in_gap && !gap_done) ? gap_cnt + GAP_W'(1) : '0;

      case (state)
        S_IDLE: if (start) begin
          state   <= S_FEED;
          pkt_cnt <= '0;
          error   <= 1'b0;
        end
        S_FEED: begin
          if (xfer_eof) begin
            state <= S_DRAIN;
          end else if (xfer_data) begin
            pkt_cnt <= pkt_cnt + PKT_W'(1);
            if (pkt_limit) begin
              state <= S_DRAIN;
              error <= 1'b1;
            end
          end
        end
        S_DRAIN: if (!hold_valid) state <= S_G1;
        S_G1: if (gap_done) begin state <= S_T1; tick <= 1'b1; end
        S_T1: state <= S_G2;
        S_G2: if (gap_done) begin state <= S_T2; tick2 <= 1'b1; end
        S_T2: state <= S_G3;
        S_G3: if (gap_done) begin state <= S_T3; tick3 <= 1'b1; end
        S_T3: state <= S_G4;
        S_G4: if (gap_done) begin
          state      <= S_CLR;
          clr_spiked <= '1;
          clr_avr    <= '1;
        end
        S_CLR: begin
          state    <= S_DECIDE;
          scan_idx <= '0;
        end
        S_DECIDE: begin
          best_idx <= win_idx;
          best_val <= take ? scan_val : best_val;
          scan_idx <= scan_idx + CLS_W'(1);
          if (last_scan) begin
            state        <= S_DONE;
            result_valid <= 1'b1;
            result_class <= win_idx;
            frame_count  <= frame_count + 16'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RANCSEQ_VOTE_READBACK_EN
  logic [VOTE_WIDTH-1:0] snap [NUM_CLASSES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= '0;
    end else if (state == S_DONE) begin
      for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= votes[i];
    end
  end

  assign vote_rd_data = (32'(vote_rd_idx) < NUM_CLASSES) ? snap[vote_rd_idx] : '0;
`endif

endmodule

// File: tb/tb_rancgrid_frame_sequencer.sv
// Bench for rancgrid_frame_sequencer: packet and result scoreboards plus per-scenario tasks.
module tb_rancgrid_frame_sequencer;
  localparam int PW = 30;
  localparam int OW = 8;
  localparam int NC = 9;
  localparam int VW = 8;
  localparam int TG = 4;
  localparam int MP = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          grid_ren = 1'b1;
  logic [OW-1:0] packet_out = '0;
  logic          packet_out_valid = 1'b0;
  logic [PW-1:0] grid_packet_in;
  logic          grid_input_buffer_empty;
  logic          tick, tick2, tick3;
  logic [2:0]    clr_spiked, clr_avr;
  logic          busy, result_valid, error;
  logic [CW-1:0] result_class;
  logic [15:0]   frame_count;
  logic [3:0]    state_dbg;
`ifdef RANCSEQ_VOTE_READBACK_EN
  logic [CW-1:0] vote_rd_idx = '0;
  logic [VW-1:0] vote_rd_data;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_frames = 0;
  int ren_mode = 0;
  logic [PW-1:0] exp_q[$];
  logic [CW-1:0] res_q[$];
  logic [PW-1:0] mon_exp;
  logic [CW-1:0] mon_res;

  rancgrid_frame_sequencer_if #(.PACKET_WIDTH(PW)) src_if ();

  rancgrid_frame_sequencer #(
    .PACKET_WIDTH(PW), .OUT_WIDTH(OW), .NUM_CLASSES(NC),
    .VOTE_WIDTH(VW), .TICK_GAP(TG), .MAX_PACKETS(MP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .src(src_if),
    .grid_packet_in(grid_packet_in), .grid_input_buffer_empty(grid_input_buffer_empty),
    .grid_ren(grid_ren), .tick(tick), .tick2(tick2), .tick3(tick3),
    .clr_spiked(clr_spiked), .clr_avr(clr_avr),
    .packet_out(packet_out), .packet_out_valid(packet_out_valid),
    .busy(busy), .result_class(result_class), .result_valid(result_valid),
    .frame_count(frame_count), .error(error),
`ifdef RANCSEQ_VOTE_READBACK_EN
    .vote_rd_idx(vote_rd_idx), .vote_rd_data(vote_rd_data),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset / grid read pattern
  always #5 clk = ~clk;

  initial begin
    src_if.src_valid  = 1'b0;
    src_if.src_packet = '0;
  end

  always @(posedge clk) begin
    #1;
    case (ren_mode)
      0:       grid_ren = 1'b1;
      1:       grid_ren = ~grid_ren;
      default: grid_ren = 1'b0;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard: packets entering the holding register vs packets the grid reads, and results
  always @(negedge clk) begin
    if (!rst) begin
      if (grid_ren && !grid_input_buffer_empty) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL grid_pkt: got %h, expected no packet", grid_packet_in);
        end else begin
          mon_exp = exp_q.pop_front();
          if (grid_packet_in !== mon_exp) begin
            n_err++;
            $display("FAIL grid_pkt: got %h, expected %h", grid_packet_in, mon_exp);
          end
        end
      end
      if (!grid_input_buffer_empty && !grid_ren) begin
        n_cmp++;
        if (src_if.src_ready !== 1'b0) begin
          n_err++;
          $display("FAIL ready_full: src_ready=%b with full register and ren=0", src_if.src_ready);
        end
      end
      if (src_if.src_valid && src_if.src_ready && !src_if.src_packet[0])
        exp_q.push_back(src_if.src_packet);
      if (result_valid) begin
        n_cmp++;
        if (res_q.size() == 0) begin
          n_err++;
          $display("FAIL result_class: got unexpected result %0d", result_class);
        end else begin
          mon_res = res_q.pop_front();
          if (result_class !== mon_res) begin
            n_err++;
            $display("FAIL result_class: got %0d, expected %0d", result_class, mon_res);
          end
        end
      end
    end
  end

  // driver tasks (called at posedge+1 unless noted)
  function automatic logic [PW-1:0] rand_pkt();
    logic [PW-1:0] p;
    p = PW'($urandom());
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic logic [PW-1:0] eof_pkt();
    logic [PW-1:0] p;
    p = PW'($urandom());
    p[0] = 1'b1;
    return p;
  endfunction

  task automatic start_frame();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_vote(input logic [OW-1:0] v);
    packet_out       = v;
    packet_out_valid = 1'b1;
    @(posedge clk); #1;
    packet_out_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [PW-1:0] p);
    int c;
    bit hit;
    c = 0;
    hit = 0;
    src_if.src_valid  = 1'b1;
    src_if.src_packet = p;
    while (!hit && c < 100) begin
      @(negedge clk);
      hit = src_if.src_ready;
      c++;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL send_pkt: packet %h not accepted within 100 cycles", p);
    end
    @(posedge clk); #1;
  endtask

  task automatic src_idle();
    src_if.src_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int c;
    bit hit;
    c = 0;
    hit = 0;
    while (!hit && c < 200) begin
      @(negedge clk);
      hit = result_valid;
      c++;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL %s_timeout: no result_valid within 200 cycles", name);
    end else begin
      exp_frames++;
      @(negedge clk);
      n_cmp++;
      if (result_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s_pulse: result_valid=%b, expected 0", name, result_valid);
      end
      n_cmp++;
      if (frame_count !== 16'(exp_frames)) begin
        n_err++;
        $display("FAIL %s_frames: frame_count=%0d, expected %0d", name, frame_count, exp_frames);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s_busy: busy=%b, expected 0", name, busy);
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (grid_input_buffer_empty !== 1'b1) begin
      n_err++; $display("FAIL reset_empty: got %b expected 1", grid_input_buffer_empty);
    end
    n_cmp++;
    if ({tick, tick2, tick3} !== 3'b000) begin
      n_err++; $display("FAIL reset_ticks: got %b expected 000", {tick, tick2, tick3});
    end
    n_cmp++;
    if ({clr_spiked, clr_avr} !== 6'b0) begin
      n_err++; $display("FAIL reset_clr: got %b expected 0", {clr_spiked, clr_avr});
    end
    n_cmp++;
    if ({result_valid, result_class, error, src_if.src_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_misc: rv=%b cls=%0d err=%b rdy=%b expected all 0",
               result_valid, result_class, error, src_if.src_ready);
    end
    n_cmp++;
    if (frame_count !== 16'd0 || grid_packet_in !== '0) begin
      n_err++;
      $display("FAIL reset_regs: frame_count=%0d grid_packet_in=%h expected 0", frame_count, grid_packet_in);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_tick_sequence();
    int t1, t2, t3, tc, trv, n1, n2, n3, nc, bad_clr;
    t1 = -1; t2 = -1; t3 = -1; tc = -1; trv = -1;
    n1 = 0; n2 = 0; n3 = 0; nc = 0; bad_clr = 0;
    ren_mode = 0;
    start_frame();
    res_q.push_back(CW'(5));
    drive_vote(8'd5); drive_vote(8'd14); drive_vote(8'd14); drive_vote(8'd3); drive_vote(8'd12);
    for (int i = 0; i < 3; i++) send_pkt(rand_pkt());
    send_pkt(eof_pkt());
    src_idle();
    // c counts cycles from the one in which the EOF edge landed (the only DRAIN cycle)
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tick === 1'b1) begin n1++; if (t1 < 0) t1 = c; end
      if (tick2 === 1'b1) begin n2++; if (t2 < 0) t2 = c; end
      if (tick3 === 1'b1) begin n3++; if (t3 < 0) t3 = c; end
      if (clr_spiked === 3'b111 && clr_avr === 3'b111) begin nc++; if (tc < 0) tc = c; end
      else if (clr_spiked !== 3'b000 || clr_avr !== 3'b000) bad_clr++;
      if (result_valid === 1'b1 && trv < 0) trv = c;
    end
    exp_frames++;
    n_cmp++; if (t1 != 5)   begin n_err++; $display("FAIL tick_time: got %0d expected 5", t1); end
    n_cmp++; if (t2 != 10)  begin n_err++; $display("FAIL tick2_time: got %0d expected 10", t2); end
    n_cmp++; if (t3 != 15)  begin n_err++; $display("FAIL tick3_time: got %0d expected 15", t3); end
    n_cmp++; if (tc != 20)  begin n_err++; $display("FAIL clr_time: got %0d expected 20", tc); end
    n_cmp++; if (trv != 30) begin n_err++; $display("FAIL result_time: got %0d expected 30", trv); end
    n_cmp++;
    if (n1 != 1 || n2 != 1 || n3 != 1 || nc != 1 || bad_clr != 0) begin
      n_err++;
      $display("FAIL pulse_width: tick=%0d tick2=%0d tick3=%0d clr=%0d badclr=%0d expected 1/1/1/1/0",
               n1, n2, n3, nc, bad_clr);
    end
    n_cmp++;
    if (frame_count !== 16'(exp_frames)) begin
      n_err++; $display("FAIL seq_frames: got %0d expected %0d", frame_count, exp_frames);
    end
  endtask

  task automatic test_tie_and_idle_votes();
    ren_mode = 0;
    // votes outside a frame must be dropped
    @(posedge clk); #1;
    drive_vote(8'd8); drive_vote(8'd17); drive_vote(8'd8);
    start_frame();
    res_q.push_back(CW'(1));
    drive_vote(8'd1); drive_vote(8'd4); drive_vote(8'd10); drive_vote(8'd13);
    send_pkt(rand_pkt());
    send_pkt(eof_pkt());
    src_idle();
    wait_result("tie");
  endtask

  task automatic test_back_to_back();
    ren_mode = 1;
    for (int f = 0; f < 3; f++) begin
      start_frame();
      res_q.push_back(CW'(f + 6));
      drive_vote(OW'(f + 6));
      drive_vote(OW'(f + 15));
      for (int i = 0; i < 3; i++) send_pkt(rand_pkt());
      send_pkt(eof_pkt());
      src_idle();
      wait_result("b2b");
    end
    ren_mode = 0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL b2b_drain: %0d packets never read, expected 0", exp_q.size());
    end
  endtask

  task automatic test_truncation();
    logic [PW-1:0] p5, p6;
    p5 = rand_pkt();
    p6 = rand_pkt();
    ren_mode = 0;
    start_frame();
    res_q.push_back(CW'(0));
    for (int i = 0; i < 4; i++) send_pkt(rand_pkt());
    src_if.src_packet = p5;
    @(negedge clk);
    n_cmp++;
    if (error !== 1'b1) begin n_err++; $display("FAIL trunc_error: got %b expected 1", error); end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_result("trunc");
    n_cmp++;
    if (error !== 1'b1) begin n_err++; $display("FAIL trunc_sticky: got %b expected 1", error); end
    start_frame();
    res_q.push_back(CW'(0));
    n_cmp++;
    if (error !== 1'b0) begin n_err++; $display("FAIL trunc_clear: got %b expected 0", error); end
    send_pkt(p5);
    send_pkt(p6);
    send_pkt(eof_pkt());
    src_idle();
    wait_result("trunc_next");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL trunc_drain: %0d packets never read, expected 0", exp_q.size());
    end
  endtask

  task automatic test_rst_mid_frame();
    ren_mode = 0;
    start_frame();
    drive_vote(8'd7); drive_vote(8'd7); drive_vote(8'd16);
    send_pkt(eof_pkt());
    src_idle();
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || {tick, tick2, tick3} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_busy: busy=%b ticks=%b expected 0/000", busy, {tick, tick2, tick3});
    end
    n_cmp++;
    if (grid_input_buffer_empty !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_empty: got %b expected 1", grid_input_buffer_empty);
    end
    n_cmp++;
    if (frame_count !== 16'd0 || error !== 1'b0 || result_class !== '0) begin
      n_err++;
      $display("FAIL rst_mid_regs: frame_count=%0d error=%b cls=%0d expected 0", frame_count, error, result_class);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_frames = 0;
    start_frame();
    res_q.push_back(CW'(0));
    send_pkt(eof_pkt());
    src_idle();
    wait_result("post_rst");
  endtask

  task automatic test_saturation();
    ren_mode = 0;
    start_frame();
    res_q.push_back(CW'(0));
    for (int i = 0; i < 300; i++) drive_vote(8'd0);
    for (int i = 0; i < 255; i++) drive_vote(8'd1);
    send_pkt(eof_pkt());
    src_idle();
    wait_result("sat");
`ifdef RANCSEQ_VOTE_READBACK_EN
    vote_rd_idx = CW'(0); #1;
    n_cmp++;
    if (vote_rd_data !== 8'd255) begin n_err++; $display("FAIL rd_idx0: got %0d expected 255", vote_rd_data); end
    vote_rd_idx = CW'(1); #1;
    n_cmp++;
    if (vote_rd_data !== 8'd255) begin n_err++; $display("FAIL rd_idx1: got %0d expected 255", vote_rd_data); end
    vote_rd_idx = CW'(2); #1;
    n_cmp++;
    if (vote_rd_data !== 8'd0) begin n_err++; $display("FAIL rd_idx2: got %0d expected 0", vote_rd_data); end
    vote_rd_idx = CW'(12); #1;
    n_cmp++;
    if (vote_rd_data !== 8'd0) begin n_err++; $display("FAIL rd_oob: got %0d expected 0", vote_rd_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_tick_sequence();
    test_tie_and_idle_votes();
    test_back_to_back();
    test_truncation();
    test_rst_mid_frame();
    test_saturation();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || res_q.size() != 0) begin
      n_err++;
      $display("FAIL final_queues: %0d packets and %0d results outstanding, expected 0", exp_q.size(), res_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
